// File: rtl/seg7_time_scan.sv
// seg7_time_scan: four-digit multiplexed 7-segment time-of-day driver.
// Scans ML/MH/HL/HH onto AN[0..3], blanks the leading hour zero, blinks the
// colon (DP in slot 2) and optionally blanks a digit pair while the time is set.
// Optional feature macro: BLINK_EN (digit-pair blinking driven by BLINK).
module seg7_time_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] HH,
  input  logic [3:0] HL,
  input  logic [2:0] MH,
  input  logic [3:0] ML,
  input  logic       SEC_TICK,
  input  logic [1:0] BLINK,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int unsigned PRE_W  = 16;
  localparam int unsigned SHD_W  = 13;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic             phase;
  logic [SHD_W-1:0] shadow;
  logic             slot_tick;

  logic [1:0] sh_hh;
  logic [3:0] sh_hl;
  logic [2:0] sh_mh;
  logic [3:0] sh_ml;

  logic [3:0] digit;
  logic [3:0] digit_max;
  logic       lead_zero;
  logic       blink_blank;
  logic [3:0] an_c;
  logic [6:0] seg_c;
  logic       dp_c;

  assign slot_tick = (pre == PRE_MAX);
  assign sh_hh     = shadow[12:11];
  assign sh_hl     = shadow[10:7];
  assign sh_mh     = shadow[6:4];
  assign sh_ml     = shadow[3:0];

  // BCD to active-low {g..a}; anything above the digit's legal maximum shows "-"
  function automatic logic [6:0] seg_digit(input logic [3:0] d, input logic [3:0] dmax);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    if (d > dmax) s = SEG_DASH;
    return s;
  endfunction

  // Prescaler, slot index, colon phase and frame-coherent digit shadow
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre    <= '0;
      idx    <= '0;
      phase  <= 1'b0;
      shadow <= '0;
    end else begin
      pre <= slot_tick ? '0 : pre + PRE_W'(1);
      if (slot_tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) shadow <= {HH, HL, MH, ML};
      end
      if (SEC_TICK) phase <= ~phase;
    end
  end

`ifdef BLINK_EN
  // Blank the selected pair during the off half of the blink period
  assign blink_blank = phase & ((BLINK[1] & idx[1]) | (BLINK[0] & ~idx[1]));
`else
  logic unused_blink;
  assign unused_blink = ^BLINK;
  assign blink_blank  = 1'b0;
`endif

  // Select the current slot's digit and form the next pin values
  always_comb begin
    digit     = sh_ml;
    digit_max = 4'd9;
    case (idx)
      2'd0: begin digit = sh_ml;               digit_max = 4'd9; end
      2'd1: begin digit = {1'b0, sh_mh};       digit_max = 4'd5; end
      2'd2: begin digit = sh_hl;               digit_max = 4'd9; end
      default: begin digit = {2'b00, sh_hh};   digit_max = 4'd2; end
    endcase
    lead_zero = (idx == 2'd3) && (sh_hh == 2'd0);
    an_c      = ~(4'b0001 << idx);
    seg_c     = (lead_zero || blink_blank) ? SEG_BLANK : seg_digit(digit, digit_max);
    dp_c      = !((idx == 2'd2) && !phase);
  end

  // Registered pin drivers
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN  <= 4'b1111;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= an_c;
      SEG <= seg_c;
      DP  <= dp_c;
    end
  end

endmodule

// File: tb/tb_seg7_time_scan.sv
// tb_seg7_time_scan: directed bench for seg7_time_scan with SCAN_DIV = 4.
module tb_seg7_time_scan;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] HH;
  logic [3:0] HL;
  logic [2:0] MH;
  logic [3:0] ML;
  logic       SEC_TICK;
  logic [1:0] BLINK;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  seg7_time_scan #(.SCAN_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .HH(HH), .HL(HL), .MH(MH), .ML(ML),
    .SEC_TICK(SEC_TICK), .BLINK(BLINK), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Advance n cycles, checking the pins after each edge
  task automatic expect_cycles(input string tag, input int n,
                               input logic [3:0] an, input logic [6:0] seg, input logic dp);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      assert ({AN, SEG, DP} === {an, seg, dp}) else begin
        errors++;
        $error("FAIL %s cyc%0d: AN=%b SEG=%b DP=%b, want AN=%b SEG=%b DP=%b",
               tag, i, AN, SEG, DP, an, seg, dp);
      end
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_time(input logic [1:0] hh, input logic [3:0] hl,
                          input logic [2:0] mh, input logic [3:0] ml);
    HH = hh; HL = hl; MH = mh; ML = ml;
  endtask

  initial begin
    RST = 1'b1; SEC_TICK = 1'b0; BLINK = 2'b00;
    set_time(2'd1, 4'd2, 3'd3, 4'd4);

    // Reset held three cycles, then first frame from a zeroed shadow
    expect_cycles("reset", 3, 4'b1111, SB, 1'b1);
    RST = 1'b0;
    expect_cycles("f1_s0", 4, 4'b1110, S0, 1'b1);
    expect_cycles("f1_s1", 4, 4'b1101, S0, 1'b1);
    expect_cycles("f1_s2", 4, 4'b1011, S0, 1'b0);
    expect_cycles("f1_s3", 4, 4'b0111, SB, 1'b1);
    // Second frame shows 12:34
    expect_cycles("f2_s0", 4, 4'b1110, S4, 1'b1);
    expect_cycles("f2_s1", 4, 4'b1101, S3, 1'b1);
    expect_cycles("f2_s2", 4, 4'b1011, S2, 1'b0);
    expect_cycles("f2_s3", 4, 4'b0111, S1, 1'b1);

    // Leading zero and out-of-range digits
    set_time(2'd0, 4'd9, 3'd7, 4'd12);
    skip(16);
    expect_cycles("inv_s0", 4, 4'b1110, SD, 1'b1);
    expect_cycles("inv_s1", 4, 4'b1101, SD, 1'b1);
    expect_cycles("inv_s2", 4, 4'b1011, S9, 1'b0);
    expect_cycles("inv_s3", 4, 4'b0111, SB, 1'b1);

    // Frame coherency: 12:59 -> 13:00 changed while slot 1 is lit
    set_time(2'd1, 4'd2, 3'd5, 4'd9);
    skip(16);
    expect_cycles("coh_s0", 4, 4'b1110, S9, 1'b1);
    expect_cycles("coh_s1a", 1, 4'b1101, S5, 1'b1);
    set_time(2'd1, 4'd3, 3'd0, 4'd0);
    expect_cycles("coh_s1b", 3, 4'b1101, S5, 1'b1);
    expect_cycles("coh_s2", 4, 4'b1011, S2, 1'b0);
    expect_cycles("coh_s3", 4, 4'b0111, S1, 1'b1);
    expect_cycles("new_s0", 4, 4'b1110, S0, 1'b1);
    expect_cycles("new_s1", 4, 4'b1101, S0, 1'b1);
    expect_cycles("new_s2", 4, 4'b1011, S3, 1'b0);
    expect_cycles("new_s3", 4, 4'b0111, S1, 1'b1);

    // Colon: one SEC_TICK turns the colon off until the next tick
    expect_cycles("col_s0a", 2, 4'b1110, S0, 1'b1);
    SEC_TICK = 1'b1;
    expect_cycles("col_s0b", 1, 4'b1110, S0, 1'b1);
    SEC_TICK = 1'b0;
    expect_cycles("col_s0c", 1, 4'b1110, S0, 1'b1);
    expect_cycles("col_s1", 4, 4'b1101, S0, 1'b1);
    expect_cycles("col_s2", 4, 4'b1011, S3, 1'b1);
    expect_cycles("col_s3", 4, 4'b0111, S1, 1'b1);

    // Hour blink with phase = 1
    BLINK = 2'b10;
    expect_cycles("blk_s0", 4, 4'b1110, S0, 1'b1);
    expect_cycles("blk_s1", 4, 4'b1101, S0, 1'b1);
`ifdef BLINK_EN
    expect_cycles("blk_s2", 4, 4'b1011, SB, 1'b1);
    expect_cycles("blk_s3", 4, 4'b0111, SB, 1'b1);
`else
    expect_cycles("blk_s2", 4, 4'b1011, S3, 1'b1);
    expect_cycles("blk_s3", 4, 4'b0111, S1, 1'b1);
`endif
    // Back to phase = 0: all digits visible, colon on
    expect_cycles("vis_s0a", 2, 4'b1110, S0, 1'b1);
    SEC_TICK = 1'b1;
    expect_cycles("vis_s0b", 1, 4'b1110, S0, 1'b1);
    SEC_TICK = 1'b0;
    expect_cycles("vis_s0c", 1, 4'b1110, S0, 1'b1);
    expect_cycles("vis_s1", 4, 4'b1101, S0, 1'b1);
    expect_cycles("vis_s2", 4, 4'b1011, S3, 1'b0);
    expect_cycles("vis_s3", 4, 4'b0111, S1, 1'b1);

    // Mid-slot reset with idx = 2, pre = 2
    expect_cycles("mr_s0", 4, 4'b1110, S0, 1'b1);
    expect_cycles("mr_s1", 4, 4'b1101, S0, 1'b1);
    expect_cycles("mr_s2", 2, 4'b1011, S3, 1'b0);
    RST = 1'b1;
    expect_cycles("mr_rst", 1, 4'b1111, SB, 1'b1);
    RST = 1'b0;
    expect_cycles("mr_after_s0", 4, 4'b1110, S0, 1'b1);
    expect_cycles("mr_after_s1", 1, 4'b1101, S0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_time_scan.md
# seg7_time_scan

Time-of-day display driver for the four-digit multiplexed 7-segment display on the Nexys 3. It sits directly downstream of the hour and minute counters and consumes their BCD digit outputs: hour tens (0–2), hour ones, minute tens (0–5) and minute ones. It time-multiplexes the four digits onto shared active-low segment lines, blanks the leading hour zero, drives a blinking colon, and blinks a selected digit pair while the time is being set.

## Interface
Parameters:
- SCAN_DIV, default 50000: CLK cycles per digit slot. At 100 MHz this gives a 2 kHz slot rate and a 500 Hz frame rate. Legal range is ≥2; the prescaler is 16 bits wide.

Ports:
- CLK  in  1  system clock; every register is clocked on the rising edge
- RST  in  1  synchronous, active-high reset
- HH  in  2  hour tens digit (BCD)
- HL  in  4  hour ones digit (BCD)
- MH  in  3  minute tens digit (BCD)
- ML  in  4  minute ones digit (BCD)
- SEC_TICK  in  1  one-cycle pulse once per second
- BLINK  in  2  bit1 blinks the hour digits; bit0 blinks the minute digits
- AN  out  4  digit enables, active low; AN[0] is the rightmost digit
- SEG  out  7  segments {g,f,e,d,c,b,a}, active low
- DP  out  1  decimal point, active low

## Operation
Prescaler:
- `pre` counts 0..SCAN_DIV-1 and wraps.
- `slot_tick` is asserted when `pre == SCAN_DIV-1`.

Slot index:
- `idx` is 2 bits and increments mod 4 on `slot_tick`.
- Digit mapping: idx0 → ML/AN[0], idx1 → MH/AN[1], idx2 → HL/AN[2], idx3 → HH/AN[3].

Shadow register:
- HH/HL/MH/ML are copied into a 13-bit shadow when `slot_tick` fires with `idx == 3`, i.e. at the frame boundary.
- This guarantees that one frame never mixes two different time values.
- Inputs that change mid-frame appear in the next frame.

Phase:
- The 1-bit `phase` toggles on every SEC_TICK.
- Result: 1 s on, 1 s off.

Decode (active low, {g..a}):
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- 9 = 0010000
- Out-of-range values (HL/ML > 9, MH > 5, HH = 3) decode to "-" = 0111111.

Blanking, evaluated per slot in this priority order:
- Leading-zero rule: in slot 3 with shadow HH = 0, SEG = 1111111 and AN[3] is still driven low.
- Blink rule (see Configuration): a blanked slot gives SEG = 1111111.

Colon: DP = 0 only in slot 2 and only while phase = 0. Otherwise DP = 1.

## Timing
Reset, one cycle:
- `pre` = 0, `idx` = 0, `phase` = 0, shadow = 0.
- AN = 1111, SEG = 1111111, DP = 1.

Output registers:
- AN/SEG/DP are registered from the current `idx`, shadow and `phase` every non-reset cycle.
- Latency from any state change to the pins is 1 cycle.

First frame after reset:
- The cycle after RST deasserts shows AN = 1110, SEG = 1000000 ("0"), DP = 1.

Slot changes:
- `idx` advances on the cycle after `pre` = SCAN_DIV-1.
- The pins follow one cycle later.
- Each digit is therefore lit for exactly SCAN_DIV cycles.

Shadow update:
- The shadow loads at the same edge where `idx` goes 3 → 0.
- Slot 0 of the new frame already shows the new ML.

Simultaneous events:
- RST beats SEC_TICK and `slot_tick`.
- SEC_TICK during `slot_tick` toggles `phase` and advances the slot on the same edge.

Mid-operation reset:
- All state returns to reset values immediately.
- A partially elapsed slot is abandoned.

Anti-ghosting: exactly one AN bit is low in any non-reset cycle.

## Configuration
- BLINK_EN defined: while phase = 1, BLINK[1] blanks slots 2 and 3 (AN still driven), and BLINK[0] blanks slots 0 and 1.
- BLINK_EN undefined: BLINK is ignored and the blink logic is not built. The colon and phase behaviour are unchanged.

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset and first slot: hold RST 3 cycles with inputs 1/2/3/4. The pins read AN = 1111, SEG = 1111111 and DP = 1 during reset, and AN = 1110 with SEG "0" on the first cycle after release, because the shadow is still 0. After the first frame boundary the digits read 4, 3, 2, 1 on AN[0..3] in successive 4-cycle slots.
- Leading zero and invalid digits: HH = 0, HL = 9, MH = 7, ML = 12. The display shows slot 3 blank with AN[3] = 0, slot 2 = 0010000, slot 1 = 0111111 and slot 0 = 0111111.
- Frame coherency: change the inputs from 12:59 to 13:00 while `idx` = 1. The remaining slots still show 12:59, and the next frame shows 13:00 starting at slot 0.
- Colon: pulse SEC_TICK once. DP = 0 in slot 2 before the pulse and DP = 1 in every slot after it until the next pulse. DP is never low outside slot 2.
- Blink: with BLINK_EN defined, BLINK = 10 and phase = 1, slots 2 and 3 give SEG = 1111111 while the minutes stay visible. With phase = 0 all four digits are visible. With the macro undefined, nothing blinks.
- Mid-slot reset: assert RST for 1 cycle while `pre` = 2 and `idx` = 2. The next cycle shows slot 0, which then lasts a full 4 cycles.
